// File: rtl/dense_neuron_accum.sv
// dense_neuron_accum
//   One output neuron of the 128-input fully connected layer that follows the
//   stride-2 conv stage. Features arrive serially (16 groups x 8 channels), are
//   multiplied by a per-neuron Q6.10 weight and accumulated onto a bias. The
//   saturated 16-bit pre-activation sum is presented with a one-cycle valid.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          begin a new frame, loads accumulator with bias
//   bias           signed Q6.10 bias, sampled when start=1
//   currentData    signed Q6.10 feature, ignored outside data slots
//   counter1       group index 0..15 (bit 4 ignored)
//   counter2       channel index 0..7 = data slots, 8..15 = idle slots
//   delayTemp      group-boundary strobe, suppresses accumulation
//   delayTwice     reserved, no effect
//   outputCounter  reserved, no effect
//   valid          one-cycle pulse when outputSum holds a new frame result
//   outputSum      signed Q6.10 saturated result, held until the next result
module dense_neuron_accum #(
    parameter int unsigned NEURON      = 0,
    parameter int unsigned FRAC_BITS   = 10,
    parameter logic [15:0] TEST_WEIGHT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic [15:0] currentData,
    input  logic [4:0]  counter1,
    input  logic [4:0]  counter2,
    input  logic        delayTemp,
    input  logic        delayTwice,
    input  logic [4:0]  outputCounter,
    output logic        valid,
    output logic [15:0] outputSum
);

    // Weight table: row NEURON, word address {group, channel}.
    function automatic logic [15:0] rom_word(input int unsigned neuron, input logic [6:0] addr);
        logic [15:0] h;
        h = ({9'd0, addr} * 16'd97) + (16'(neuron) * 16'd211) + 16'd1357;
        return {{4{h[11]}}, h[11:0]};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    logic signed [31:0] r_acc;
    logic               r_active;
    logic               r_valid;
    logic [15:0]        r_out;

    logic [6:0]         w_addr;
    logic [15:0]        w_weight;
    logic signed [31:0] w_data32;
    logic signed [31:0] w_weight32;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_term;
    logic signed [31:0] w_acc_sum;
    logic               w_data_slot;
    logic               w_acc_en;
    logic               w_last;
    logic               w_unused;

    assign w_addr   = {counter1[3:0], counter2[2:0]};
    assign w_weight = (TEST_WEIGHT != 16'h0000) ? TEST_WEIGHT : rom_word(NEURON, w_addr);

    // Both operands widened first so the product is a full 32-bit signed result.
    assign w_data32   = {{16{currentData[15]}}, currentData};
    assign w_weight32 = {{16{w_weight[15]}}, w_weight};
    assign w_prod     = w_data32 * w_weight32;
    assign w_term     = w_prod >>> FRAC_BITS;
    assign w_acc_sum  = r_acc + w_term;

    assign w_data_slot = (counter2[4:3] == 2'b00);
    assign w_acc_en    = r_active & ~start & ~delayTemp & w_data_slot;
    assign w_last      = w_acc_en & (counter1[3:0] == 4'hF) & (counter2[2:0] == 3'd7);

    assign w_unused = ^{counter1[4], delayTwice, outputCounter};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
            r_out    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (start) begin
                // Restart from bias; this cycle's data is deliberately dropped.
                r_acc    <= {{16{bias[15]}}, bias};
                r_active <= 1'b1;
            end else if (w_acc_en) begin
                r_acc <= w_acc_sum;
                if (w_last) begin
                    r_out    <= sat16(w_acc_sum);
                    r_valid  <= 1'b1;
                    r_active <= 1'b0;
                end
            end
        end
    end

    assign valid     = r_valid;
    assign outputSum = r_out;

endmodule

// File: tb/tb_dense_neuron_accum.sv
// Bench for dense_neuron_accum: two instances (weight 1.0 and weight ~32.0)
// share stimulus; a frame model pushes expected sums to per-instance queues
// that are popped when each DUT raises valid.
module tb_dense_neuron_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bias;
    logic [15:0] currentData;
    logic [4:0]  counter1;
    logic [4:0]  counter2;
    logic        delayTemp;
    logic        delayTwice;
    logic [4:0]  outputCounter;
    logic        valid_a, valid_b;
    logic [15:0] sum_a, sum_b;

    localparam logic [15:0] WA = 16'h0400;
    localparam logic [15:0] WB = 16'h7FFF;

    int checks   = 0;
    int failures = 0;

    logic [15:0]        q_a[$];
    logic [15:0]        q_b[$];
    logic signed [31:0] m_acc_a, m_acc_b;
    logic               m_active;
    logic               m_vexp;
    logic [15:0]        m_hold_a, m_hold_b;

    always #5 clk = ~clk;

    dense_neuron_accum #(.NEURON(0), .FRAC_BITS(10), .TEST_WEIGHT(WA)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .bias(bias), .currentData(currentData),
        .counter1(counter1), .counter2(counter2), .delayTemp(delayTemp),
        .delayTwice(delayTwice), .outputCounter(outputCounter),
        .valid(valid_a), .outputSum(sum_a)
    );

    dense_neuron_accum #(.NEURON(3), .FRAC_BITS(10), .TEST_WEIGHT(WB)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .bias(bias), .currentData(currentData),
        .counter1(counter1), .counter2(counter2), .delayTemp(delayTemp),
        .delayTwice(delayTwice), .outputCounter(outputCounter),
        .valid(valid_b), .outputSum(sum_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic signed [31:0] v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic signed [31:0] term(input logic [15:0] d, input logic [15:0] w);
        logic signed [63:0] p;
        p = $signed({{48{d[15]}}, d}) * $signed({{48{w[15]}}, w});
        p = p >>> 10;
        return p[31:0];
    endfunction

    task automatic check_outputs();
        check("valid_a", {15'd0, valid_a}, {15'd0, m_vexp});
        check("valid_b", {15'd0, valid_b}, {15'd0, m_vexp});
        if (valid_a === 1'b1) begin
            if (q_a.size() == 0) check("extra_valid_a", {15'd0, valid_a}, 16'h0000);
            else check("sb_sum_a", sum_a, q_a.pop_front());
        end
        if (valid_b === 1'b1) begin
            if (q_b.size() == 0) check("extra_valid_b", {15'd0, valid_b}, 16'h0000);
            else check("sb_sum_b", sum_b, q_b.pop_front());
        end
        check("hold_a", sum_a, m_hold_a);
        check("hold_b", sum_b, m_hold_b);
    endtask

    // Drive one slot, advance the model, clock, then compare.
    task automatic slot(input logic st, input logic [15:0] b, input logic [15:0] d,
                        input logic [4:0] c1, input logic [4:0] c2, input logic dt);
        start         = st;
        bias          = b;
        currentData   = d;
        counter1      = c1;
        counter2      = c2;
        delayTemp     = dt;
        delayTwice    = 1'($urandom);
        outputCounter = 5'($urandom);
        m_vexp = 1'b0;
        if (st) begin
            m_acc_a  = {{16{b[15]}}, b};
            m_acc_b  = {{16{b[15]}}, b};
            m_active = 1'b1;
        end else if (m_active && !dt && c2 < 5'd8) begin
            m_acc_a = m_acc_a + term(d, WA);
            m_acc_b = m_acc_b + term(d, WB);
            if (c1[3:0] == 4'hF && c2 == 5'd7) begin
                q_a.push_back(sat(m_acc_a));
                q_b.push_back(sat(m_acc_b));
                m_hold_a = sat(m_acc_a);
                m_hold_b = sat(m_acc_b);
                m_vexp   = 1'b1;
                m_active = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        m_acc_a = '0; m_acc_b = '0; m_active = 1'b0; m_vexp = 1'b0;
        m_hold_a = '0; m_hold_b = '0;
        check("rst_async_sum_a", sum_a, 16'h0000);
        check("rst_async_valid_a", {15'd0, valid_a}, 16'h0000);
        check("rst_async_sum_b", sum_b, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_held_sum_a", sum_a, 16'h0000);
        check("rst_held_valid_a", {15'd0, valid_a}, 16'h0000);
        reset = 1'b1;
    endtask

    task automatic run_frame(input logic [15:0] b, input logic [15:0] d, input int strobe_g,
                             input logic x_idle, input int abort_g);
        // Start slot carries real data that must not be accumulated.
        slot(1'b1, b, d, 5'd0, 5'd0, 1'b0);
        for (int g = 0; g < 16; g++) begin
            if (g == abort_g) reset_pulse();
            for (int c = 0; c < 10; c++) begin
                logic [15:0] dd;
                dd = (c >= 8 && x_idle) ? 16'hxxxx : d;
                slot(1'b0, b, dd, 5'(g), 5'(c), (g == strobe_g && c == 3));
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; bias = '0; currentData = '0;
        counter1 = '0; counter2 = '0; delayTemp = 1'b0; delayTwice = 1'b0;
        outputCounter = '0;
        m_acc_a = '0; m_acc_b = '0; m_active = 1'b0; m_vexp = 1'b0;
        m_hold_a = '0; m_hold_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum_a", sum_a, 16'h0000);
        check("reset_valid_a", {15'd0, valid_a}, 16'h0000);
        check("reset_sum_b", sum_b, 16'h0000);
        check("reset_valid_b", {15'd0, valid_b}, 16'h0000);
        reset = 1'b1;

        // Reset release alone must not start a frame.
        for (int c = 0; c < 10; c++) slot(1'b0, 16'h0400, 16'h0100, 5'd15, 5'(c), 1'b0);

        run_frame(16'h0400, 16'h0000, -1, 1'b0, -1);
        check("bias_only_a", sum_a, 16'h0400);

        run_frame(16'h0000, 16'h0008, -1, 1'b0, -1);
        check("full_sum_a", sum_a, 16'h0400);
        check("full_sum_b", sum_b, 16'h7F80);

        run_frame(16'h0000, 16'h0008, 5, 1'b1, -1);
        check("strobe_x_a", sum_a, 16'h03F8);

        run_frame(16'h0000, 16'h7FFF, -1, 1'b0, -1);
        check("sat_pos_a", sum_a, 16'h7FFF);
        check("sat_pos_b", sum_b, 16'h7FFF);

        run_frame(16'h0000, 16'h8001, -1, 1'b0, -1);
        check("sat_neg_a", sum_a, 16'h8000);
        check("sat_neg_b", sum_b, 16'h8000);

        // Abort at group 7; remaining groups run with no start, so no valid.
        run_frame(16'h0000, 16'h0008, -1, 1'b0, 7);
        check("abort_sum_a", sum_a, 16'h0000);
        run_frame(16'h0000, 16'h0008, -1, 1'b0, -1);
        check("after_abort_a", sum_a, 16'h0400);

        // Partial frame, then restart: partial sum must be discarded.
        slot(1'b1, 16'h0400, 16'h0000, 5'd0, 5'd0, 1'b0);
        for (int c = 0; c < 8; c++) slot(1'b0, 16'h0400, 16'h0400, 5'd0, 5'(c), 1'b0);
        run_frame(16'hFC00, 16'h0000, -1, 1'b0, -1);
        check("restart_neg_a", sum_a, 16'hFC00);

        check("queue_a_drained", 16'(q_a.size()), 16'h0000);
        check("queue_b_drained", 16'(q_b.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
